// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared state encoding and address helpers for the BRAM sample streamer
package bram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_e;

    // Enough slots to cover every read in the BRAM pipeline, the held output word and one spare
    function automatic int buf_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

    // Next sequential address, wrapping from depth-1 back to 0
    function automatic int wrap_inc(input int addr, input int depth);
        return (addr >= depth - 1) ? 0 : addr + 1;
    endfunction

    // A window that starts beyond the populated memory falls back to address 0
    function automatic int clamp_addr(input int addr, input int depth);
        return (addr >= depth) ? 0 : addr;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - register FIFO holding returned read words with their pass-end tag
module stream_skid_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_tvalid_i,
    input  logic [WIDTH-1:0] s_tdata_i,
    output logic             m_tvalid_o,
    output logic [WIDTH-1:0] m_tdata_o,
    input  logic             m_tready_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The issuing side only reads when a slot is guaranteed, so pushes never overflow
    assign push       = s_tvalid_i;
    assign pop        = m_tvalid_o && m_tready_i;
    assign m_tvalid_o = (cnt_q != '0);
    assign m_tdata_o  = slot_q[rd_ptr_q];
    assign count_o    = cnt_q;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Storage and pointer registers; reset clears the slots so the output word reads as zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                slot_q[wr_ptr_q] <= s_tdata_i;
            end
        end
    end

endmodule

// File: rtl/bram_sample_streamer.sv
// rtl/bram_sample_streamer.sv - walks a BRAM address window and streams its samples over valid/ready
module bram_sample_streamer
    import bram_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 251,
    parameter int RD_LAT = 1
) (
    input  logic              CLK100MHZ,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int BUF_DEPTH = buf_depth(RD_LAT);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

    stream_state_e     state_q, state_d;
    logic [ADDR_W-1:0] win_start_q, win_start_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W:0]   pass_q, pass_d;
    logic              done_q, done_d;

    // One bit per cycle of BRAM latency; bit RD_LAT-1 marks the read whose data is on mem_dout now
    logic [RD_LAT-1:0] rd_vld_q, rd_last_q;
    logic [RD_LAT:0]   rd_vld_ext, rd_last_ext;

    logic              issue;
    logic              is_last;
    logic              credit_ok;
    logic              drained;
    logic [ADDR_W-1:0] start_clamped;
    logic [CNT_W-1:0]  buf_count;
    logic [DATA_W:0]   buf_tdata;
    logic              buf_tvalid;

    assign start_clamped = ADDR_W'(clamp_addr(int'(start_addr), DEPTH));
    assign is_last       = (pass_q == len_q - 1'b1);
    // Reads in flight plus words already buffered must never exceed the buffer size
    assign credit_ok     = ($countones(rd_vld_q) + int'(buf_count)) < BUF_DEPTH;
    // Finished when nothing is in flight and the buffer empties by the end of this cycle
    assign drained       = (rd_vld_q == '0) &&
                           ((buf_count == '0) || ((buf_count == CNT_W'(1)) && out_ready));

    assign rd_vld_ext  = {rd_vld_q, issue};
    assign rd_last_ext = {rd_last_q, issue && is_last};

    // Next-state, read issue and window bookkeeping
    always_comb begin
        state_d     = state_q;
        win_start_d = win_start_q;
        len_d       = len_q;
        loop_d      = loop_q;
        cur_d       = cur_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // done_q high means this is the completion cycle, where a new start is not taken
                if (start && !done_q) begin
                    win_start_d = start_clamped;
                    len_d       = length;
                    loop_d      = loop_en;
                    cur_d       = start_clamped;
                    pass_d      = '0;
                    state_d     = (length == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                // A stop still lets the pass-final read go out so that pass ends with its last tag
                issue = credit_ok && (!stop || is_last);
                if (issue) begin
                    if (is_last) begin
                        pass_d = '0;
                        cur_d  = win_start_q;
                        if (!loop_q) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        pass_d = pass_q + 1'b1;
                        cur_d  = ADDR_W'(wrap_inc(int'(cur_q), DEPTH));
                    end
                end
                if (stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_start_q <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            cur_q       <= '0;
            pass_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_start_q <= win_start_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            cur_q       <= cur_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
        end
    end

    // Track each issued read (and its pass-end tag) until its BRAM data is valid
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            rd_vld_q  <= '0;
            rd_last_q <= '0;
        end else begin
            rd_vld_q  <= rd_vld_ext[RD_LAT-1:0];
            rd_last_q <= rd_last_ext[RD_LAT-1:0];
        end
    end

    stream_skid_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk_i      (CLK100MHZ),
        .rst_i      (rst),
        .s_tvalid_i (rd_vld_ext[RD_LAT]),
        .s_tdata_i  ({rd_last_ext[RD_LAT], mem_dout}),
        .m_tvalid_o (buf_tvalid),
        .m_tdata_o  (buf_tdata),
        .m_tready_i (out_ready),
        .count_o    (buf_count)
    );

    assign mem_en    = issue;
    assign mem_addr  = cur_q;
    assign out_valid = buf_tvalid;
    assign out_data  = buf_tdata[DATA_W-1:0];
    assign out_last  = buf_tdata[DATA_W];
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule
